// File: rtl/sc_dot_product_seq_if.sv
// Operand request / count response handshake bundle for sc_dot_product_seq.
interface sc_dot_product_seq_if #(
    parameter int LENGTH      = 3,
    parameter int WIDTH       = 8,
    parameter int STREAM_LOG2 = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LENGTH*WIDTH-1:0]   data_bin;
    logic [LENGTH*WIDTH-1:0]   weights_bin;
    logic                      out_valid;
    logic                      out_ready;
    logic [STREAM_LOG2:0]      result_count;

    modport master (
        output in_valid, data_bin, weights_bin, out_ready,
        input  in_ready, out_valid, result_count
    );

    modport slave (
        input  in_valid, data_bin, weights_bin, out_ready,
        output in_ready, out_valid, result_count
    );
endinterface

// File: rtl/sc_dot_product_seq.sv
// Binary-to-stochastic sequencer: drives the dot-product datapath for a fixed
// 2^STREAM_LOG2 window and returns the ones-count of its output stream.
module sc_dot_product_seq #(
    parameter int LENGTH      = 3,
    parameter int WIDTH       = 8,
    parameter int STREAM_LOG2 = 8,
    parameter int DP_LATENCY  = 2
) (
    input  logic              clk,
    input  logic              rst,
    sc_dot_product_seq_if.slave bus,
    output logic              dp_rst,
    output logic [LENGTH-1:0] dp_data,
    output logic [LENGTH-1:0] dp_weights,
    output logic [LENGTH-1:0] dp_sel,
    input  logic              dp_result
);
    localparam logic [15:0] SEED_A = 16'hACE1;
    localparam logic [15:0] SEED_B = 16'h1D2B;
    localparam logic [15:0] SEED_C = 16'h5A5A;
    localparam logic [STREAM_LOG2-1:0] CNT_ONE    = STREAM_LOG2'(1);
    localparam logic [STREAM_LOG2-1:0] DRAIN_LAST = STREAM_LOG2'(DP_LATENCY - 1);
    localparam logic [STREAM_LOG2:0]   ACC_ONE    = (STREAM_LOG2 + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [LENGTH*WIDTH-1:0] data_q, data_d;
    logic [LENGTH*WIDTH-1:0] wts_q, wts_d;
    logic [15:0]             lfsr_a_q, lfsr_a_d;
    logic [15:0]             lfsr_b_q, lfsr_b_d;
    logic [15:0]             lfsr_c_q, lfsr_c_d;
    logic [STREAM_LOG2-1:0]  cnt_q, cnt_d;
    logic [STREAM_LOG2:0]    acc_q, acc_d;
    logic [STREAM_LOG2:0]    res_q, res_d;
    logic [DP_LATENCY-1:0]   vld_q, vld_d;
    logic [LENGTH-1:0]       sd_q, sd_d;
    logic [LENGTH-1:0]       sw_q, sw_d;
    logic [LENGTH-1:0]       ss_q, ss_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
    endfunction

    // Low WIDTH bits of x rotated left by sh (WIDTH <= 16).
    function automatic logic [WIDTH-1:0] rot_lsbs(input logic [15:0] x, input int unsigned sh);
        logic [31:0] t;
        t = {x, x} << sh;
        return t[16 +: WIDTH];
    endfunction

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        wts_d    = wts_q;
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        lfsr_c_d = lfsr_c_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        res_d    = res_q;
        vld_d    = (vld_q << 1) | DP_LATENCY'(state_q == S_RUN);
        sd_d     = '0;
        sw_d     = '0;
        ss_d     = '0;

        if (vld_q[DP_LATENCY-1] && dp_result) acc_d = acc_q + ACC_ONE;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.data_bin;
                    wts_d   = bus.weights_bin;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                lfsr_a_d = SEED_A;
                lfsr_b_d = SEED_B;
                lfsr_c_d = SEED_C;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == '1) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d    = cnt_q + CNT_ONE;
                    lfsr_a_d = lfsr_step(lfsr_a_q);
                    lfsr_b_d = lfsr_step(lfsr_b_q);
                    lfsr_c_d = lfsr_step(lfsr_c_q);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    res_d   = acc_d;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Streams are computed from the LFSR values about to be registered so
        // the stream registers line up exactly with the RUN state.
        if (state_d == S_RUN) begin
            for (int unsigned i = 0; i < LENGTH; i++) begin
                sd_d[i] = data_q[i*WIDTH +: WIDTH] > rot_lsbs(lfsr_a_d, i);
                sw_d[i] = wts_q[i*WIDTH +: WIDTH] > rot_lsbs(lfsr_b_d, i);
                ss_d[i] = lfsr_c_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            wts_q    <= '0;
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
            lfsr_c_q <= SEED_C;
            cnt_q    <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            vld_q    <= '0;
            sd_q     <= '0;
            sw_q     <= '0;
            ss_q     <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            wts_q    <= wts_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            lfsr_c_q <= lfsr_c_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            vld_q    <= vld_d;
            sd_q     <= sd_d;
            sw_q     <= sw_d;
            ss_q     <= ss_d;
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.out_valid    = (state_q == S_DONE);
    assign bus.result_count = res_q;
    assign dp_rst           = !((state_q == S_RUN) || (state_q == S_DRAIN));
    assign dp_data          = sd_q;
    assign dp_weights       = sw_q;
    assign dp_sel           = ss_q;
endmodule

// File: tb/tb_sc_dot_product_seq.sv
// Randomized scoreboard bench for sc_dot_product_seq with a behavioural
// datapath stand-in and a window-level reference model.
module tb_sc_dot_product_seq;
    localparam int LENGTH      = 3;
    localparam int WIDTH       = 8;
    localparam int STREAM_LOG2 = 8;
    localparam int DP_LATENCY  = 2;
    localparam int WIN         = 2 ** STREAM_LOG2;
    localparam int NSAMP       = WIN + DP_LATENCY;
    localparam int VW          = LENGTH * WIDTH;
    localparam int LATENCY     = 1 + WIN + DP_LATENCY + 1;

    typedef struct {
        int cnt;
        int hs;
        bit rng;
        bit sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic dp_rst;
    logic [LENGTH-1:0] dp_data, dp_weights, dp_sel;
    logic dp_result;
    logic [DP_LATENCY-1:0] pipe = '0;
    int dp_mode = 0;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    logic [3*LENGTH-1:0] exp_stream [0:NSAMP-1];

    sc_dot_product_seq_if #(.LENGTH(LENGTH), .WIDTH(WIDTH), .STREAM_LOG2(STREAM_LOG2)) bus ();

    sc_dot_product_seq #(
        .LENGTH(LENGTH), .WIDTH(WIDTH), .STREAM_LOG2(STREAM_LOG2), .DP_LATENCY(DP_LATENCY)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .dp_rst(dp_rst), .dp_data(dp_data),
        .dp_weights(dp_weights), .dp_sel(dp_sel), .dp_result(dp_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: mode 0 priority-mux of products, 1 constant one,
    // 2 inverted parity (non-zero on idle inputs, exposes window misalignment).
    function automatic logic dp_func(input int mode, input logic [LENGTH-1:0] d, w, s);
        logic [LENGTH-1:0] p;
        logic r;
        p = d & w;
        if (mode == 1) return 1'b1;
        if (mode == 2) return ~^{p, s};
        r = p[LENGTH-1];
        for (int i = LENGTH - 1; i >= 0; i--) if (s[i]) r = p[i];
        return r;
    endfunction

    always @(posedge clk) pipe <= (pipe << 1) | DP_LATENCY'(dp_func(dp_mode, dp_data, dp_weights, dp_sel));
    assign dp_result = pipe[DP_LATENCY-1];

    function automatic int lfsr_next(input int x);
        return ((x << 1) & 32'hFFFF) | ($countones(x & 32'hD008) & 1);
    endfunction

    function automatic int rotl16(input int x, input int i);
        return ((x << i) | (x >> (16 - i))) & 32'hFFFF;
    endfunction

    task automatic build_model(input logic [VW-1:0] d, w, input int mode, output int cnt);
        int a, b, c, dv, wv, mask;
        logic [LENGTH-1:0] ds, ws, ss;
        a = 32'hACE1; b = 32'h1D2B; c = 32'h5A5A;
        mask = (1 << WIDTH) - 1;
        cnt = 0;
        for (int k = 0; k < WIN; k++) begin
            for (int i = 0; i < LENGTH; i++) begin
                dv = int'(d[i*WIDTH +: WIDTH]);
                wv = int'(w[i*WIDTH +: WIDTH]);
                ds[i] = dv > (rotl16(a, i) & mask);
                ws[i] = wv > (rotl16(b, i) & mask);
                ss[i] = c[i];
            end
            exp_stream[k] = {ds, ws, ss};
            cnt += int'(dp_func(mode, ds, ws, ss));
            a = lfsr_next(a); b = lfsr_next(b); c = lfsr_next(c);
        end
        for (int k = WIN; k < NSAMP; k++) exp_stream[k] = '0;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LENGTH; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    function automatic logic [VW-1:0] fill(input int val);
        logic [VW-1:0] v;
        for (int i = 0; i < LENGTH; i++) v[i*WIDTH +: WIDTH] = WIDTH'(val);
        return v;
    endfunction

    // Monitor: stream capture, latency, result and hold-stability checks.
    initial begin
        logic [3*LENGTH-1:0] samp[$];
        bit seen;
        int unstable, bad, ones, rng_ok, r;
        logic [STREAM_LOG2:0] held;
        exp_t e;
        seen = 0; unstable = 0; held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                samp.delete();
                seen = 0;
            end else begin
                if (!dp_rst) samp.push_back({dp_data, dp_weights, dp_sel});
                if (!bus.out_valid) seen = 0;
                else begin
                    if (!seen) begin
                        seen = 1; held = bus.result_count; unstable = 0;
                        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
                        else begin
                            chk("latency", cyc - sb[0].hs, LATENCY);
                            bad = 0;
                            if (samp.size() != NSAMP) bad = 1000 + samp.size();
                            else for (int k = 0; k < NSAMP; k++) if (samp[k] != exp_stream[k]) bad++;
                            chk("streams", bad, 0);
                            if (sb[0].sel && samp.size() >= WIN) begin
                                rng_ok = 1;
                                for (int j = 0; j < LENGTH; j++) begin
                                    ones = 0;
                                    for (int k = 0; k < WIN; k++) ones += int'(samp[k][j]);
                                    if (ones < 112 || ones > 144) rng_ok = 0;
                                end
                                chk("sel_ones_in_range", rng_ok, 1);
                            end
                        end
                    end else if (bus.result_count != held) unstable++;
                    if (bus.out_ready && sb.size() > 0) begin
                        e = sb.pop_front();
                        r = int'(bus.result_count);
                        chk("result_count", r, e.cnt);
                        chk("result_hold", unstable, 0);
                        if (e.rng) chk("result_in_48_80", (r >= 48 && r <= 80), 1);
                        samp.delete();
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic accept(input logic [VW-1:0] d, w, input int mode, input bit rng, input bit sel, output bit ok);
        int cnt;
        exp_t e;
        ok = 0;
        @(posedge clk); #1;
        bus.data_bin = d; bus.weights_bin = w; bus.in_valid = 1'b1; dp_mode = mode;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        build_model(d, w, mode, cnt);
        e.cnt = cnt; e.hs = cyc; e.rng = rng; e.sel = sel;
        sb.push_back(e);
    endtask

    task automatic run_txn(input logic [VW-1:0] d, w, input int mode, input bit hold,
                           input int bp, input bit rng, input bit sel);
        bit ok, got;
        int ir_bad;
        accept(d, w, mode, rng, sel, ok);
        if (!ok) return;
        @(posedge clk); #1;
        if (hold) begin bus.data_bin = rand_vec(); bus.weights_bin = rand_vec(); end
        else bus.in_valid = 1'b0;
        ir_bad = 0; got = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin got = 1; break; end
            if (bus.in_ready) ir_bad++;
            @(posedge clk); #1;
            if (hold) begin bus.data_bin = rand_vec(); bus.weights_bin = rand_vec(); end
        end
        chk("in_ready_low_while_busy", ir_bad, 0);
        if (!got) begin
            chk("result_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        repeat (bp) @(posedge clk);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_before_accept", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after_accept", bus.in_ready, 1);
        chk("out_valid_after_accept", bus.out_valid, 0);
    endtask

    task automatic abort_txn(input logic [VW-1:0] d, w, input int mode);
        bit ok;
        exp_t e;
        accept(d, w, mode, 0, 0, ok);
        if (!ok) return;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (101) @(posedge clk);
        #2;
        chk("in_run_before_abort", dp_rst, 0);
        #1 rst = 1'b1;
        #1;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_result_count", bus.result_count, 0);
        chk("abort_dp_rst", dp_rst, 1);
        chk("abort_streams", {dp_data, dp_weights, dp_sel}, 0);
        e = sb.pop_back();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_abort", bus.in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] d, w;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.data_bin = '0; bus.weights_bin = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_result_count", bus.result_count, 0);
        chk("reset_dp_rst", dp_rst, 1);
        chk("reset_dp_data", dp_data, 0);
        chk("reset_dp_weights", dp_weights, 0);
        chk("reset_dp_sel", dp_sel, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(fill(0), rand_vec(), 0, 0, 0, 0, 0);
        run_txn(fill(128), fill(128), 0, 0, 0, 1, 1);
        run_txn(rand_vec(), rand_vec(), 2, 1, 2, 0, 0);
        d = rand_vec(); w = rand_vec();
        run_txn(d, w, 0, 0, 0, 0, 0);
        run_txn(d, w, 0, 0, 0, 0, 0);
        run_txn(rand_vec(), rand_vec(), 2, 0, 50, 0, 0);
        d = rand_vec(); w = rand_vec();
        abort_txn(d, w, 2);
        run_txn(d, w, 2, 0, 1, 0, 0);
        run_txn(fill(255), fill(255), 1, 0, 0, 0, 0);
        for (int t = 0; t < 4; t++)
            run_txn(rand_vec(), rand_vec(), $urandom_range(0, 2), 0, $urandom_range(0, 5), 0, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
